// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the two-port block_ram arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bram_arb_pkg;

  localparam int NUM_REQ    = 2;
  localparam int RD_LATENCY = 2;

  // One entry of the read-tag pipeline: which port a RAM read belongs to.
  typedef struct packed {
    logic valid;
    logic port;
  } rd_tag_t;

  // Turn a read tag into the per-port response strobe.
  function automatic logic [NUM_REQ-1:0] tag_to_onehot(input rd_tag_t t);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    if (t.valid) begin
      oh[t.port] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant with a last-served pointer.
// Latency: grant is combinational from valid; pointer moves on the advance edge.
// Backpressure: a lone requester is always granted; contention alternates.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  // Index of the port that completed the most recent transfer.
  // Reset to 1 so that port 0 wins the first contended cycle.
  logic last;

  // Lone requester wins outright; on contention the port not served last wins.
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Pointer follows the granted port, but only when a transfer really happens.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (advance) begin
      last <= grant[1];
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one single-port block_ram between two valid/ready requesters.
// Latency: command registered at acceptance; read data returns two edges after acceptance.
// Backpressure: one request accepted per cycle, round-robin under contention; no response backpressure.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1024
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_REQ-1:0]                      req_valid,
  output logic [NUM_REQ-1:0]                      req_ready,
  input  logic [NUM_REQ-1:0]                      req_we,
  input  logic [NUM_REQ-1:0][$clog2(DEPTH)-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]           req_wdata,
  output logic [NUM_REQ-1:0]                      rsp_valid,
  output logic [WIDTH-1:0]                        rsp_rdata,
  output logic                                    ram_write_en,
  output logic                                    ram_read_en,
  output logic [$clog2(DEPTH)-1:0]                ram_addr,
  output logic [WIDTH-1:0]                        ram_data_in,
  input  logic [WIDTH-1:0]                        ram_data_out
);

  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] xfer_vec;
  logic               xfer;
  logic               sel;
  logic               sel_we;
  rd_tag_t            tag_s1;
  rd_tag_t            tag_s2;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   (req_valid),
    .advance (xfer),
    .grant   (grant)
  );

  // Grants are masked during reset so nothing is accepted on a reset edge.
  always_comb begin
    req_ready = rst ? '0 : grant;
  end

  // Decode the handshake: at most one port transfers, sel names it.
  always_comb begin
    xfer_vec = req_valid & req_ready;
    xfer     = |xfer_vec;
    sel      = xfer_vec[1];
    sel_we   = req_we[sel];
  end

  // Command stage: register the accepted request towards the RAM.
  // Address and data hold when idle so the RAM pins only toggle on real accesses.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_write_en <= 1'b0;
      ram_read_en  <= 1'b0;
      ram_addr     <= '0;
      ram_data_in  <= '0;
    end else begin
      ram_write_en <= xfer & sel_we;
      ram_read_en  <= xfer & ~sel_we;
      if (xfer) begin
        ram_addr    <= req_addr[sel];
        ram_data_in <= req_wdata[sel];
      end
    end
  end

  // Read-tag pipeline: stage 1 lines up with read_en, stage 2 with data_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_s1 <= '0;
      tag_s2 <= '0;
    end else begin
      tag_s1.valid <= xfer & ~sel_we;
      tag_s1.port  <= sel;
      tag_s2       <= tag_s1;
    end
  end

  // Responses: the tag steers the strobe, data is the RAM output as-is.
  always_comb begin
    rsp_valid = tag_to_onehot(tag_s2);
    rsp_rdata = ram_data_out;
  end

  // Structural invariants of the handshake and the RAM command.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(req_ready)) else $error("req_ready not one-hot");
      assert ($onehot0(rsp_valid)) else $error("rsp_valid not one-hot");
      assert (!(ram_write_en && ram_read_en)) else $error("read and write enable together");
    end
  end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one single-port block_ram between two requesters, port 0 and port 1.
- Uses round-robin arbitration and a valid/ready request handshake on each port.
- Drives the RAM through registered command outputs and routes each read result back to the requester that issued it.
- Sits between the block_ram instance and two client blocks, for example a DMA engine and a CPU-side register port.

Parameters:
- WIDTH, 16: data word width, in bits; matches block_ram WIDTH.
- DEPTH, 1024: number of RAM words; address width is $clog2(DEPTH).

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  [1:0]  request valid, one bit per port.
- req_ready  output  [1:0]  request accepted; one-hot or zero.
- req_we  input  [1:0]  1 = write, 0 = read, per port.
- req_addr  input  [1:0][$clog2(DEPTH)-1:0]  word address, per port.
- req_wdata  input  [1:0][WIDTH-1:0]  write data, per port.
- rsp_valid  output  [1:0]  read data valid, one-cycle pulse per port.
- rsp_rdata  output  [WIDTH-1:0]  read data; shared by both ports and qualified by rsp_valid.
- ram_write_en  output  1  to block_ram write_en.
- ram_read_en  output  1  to block_ram read_en.
- ram_addr  output  $clog2(DEPTH)  to block_ram addr.
- ram_data_in  output  WIDTH  to block_ram data_in.
- ram_data_out  input  WIDTH  from block_ram data_out; registered, valid the cycle after read_en is sampled.

Behaviour:
- Reset (rst=1 at a clock edge):
  - ram_write_en, ram_read_en, ram_addr, ram_data_in, rsp_valid all 0.
  - Priority pointer set to favour port 0.
  - Read-tag pipeline cleared.
  - req_ready is 0 while rst is high.
- Arbitration is combinational from req_valid and the priority pointer:
  - One port valid: that port is granted.
  - Both valid: the port other than the last-accepted port is granted.
  - Neither valid: req_ready = 0.
- Transfer occurs on req_valid[i] & req_ready[i] at a rising edge. The priority pointer updates only on a transfer, to "last = i".
- Requester rules:
  - A requester holds req_valid, req_we, req_addr and req_wdata stable until accepted.
  - The arbiter never deasserts a grant while its port is valid and the other port is idle.
- Command stage, at acceptance edge E0:
  - ram_addr, ram_data_in, ram_write_en = req_we and ram_read_en = ~req_we are registered.
  - Non-accepting cycle: both enables register 0; addr/data hold their previous value.
- Read tag pipeline:
  - Stage 1 is set at E0 with the port index plus a valid bit (reads only).
  - Stage 2 is set at E1 from stage 1.
  - rsp_valid[tag] = 1 for exactly the cycle after E1. rsp_rdata = ram_data_out, combinational pass-through.
  - Read latency: 2 edges from acceptance to rsp_valid.
  - Writes produce no response.
- Throughput is one access per cycle with no bubbles. Reads and writes are served in acceptance order.
- Read-after-write to the same address, accepted on consecutive cycles, returns the new data.
- Both rsp_valid bits are never high together; responses are strictly in order.
- Reset mid-operation drops in-flight reads: no rsp_valid after rst, and no RAM enable in the cycle after rst.
- Address width is exact; DEPTH need not be a power of 2. Out-of-range addresses are the requester's responsibility and are passed through unchecked.

Decomposition:
- Package bram_arb_pkg holds:
  - NUM_REQ = 2.
  - RD_LATENCY = 2.
  - typedef rd_tag_t, a struct {logic valid; logic port;}.
- Sub-module rr_arbiter2: 2-input round-robin grant with pointer register, inputs valid[1:0] and advance, output grant[1:0].
- block_ram is instantiated by the parent, not inside this block.

Test Plan:
- Post-reset, both ports valid the same cycle (port 0: write 16'hABCD at addr 10; port 1: write 16'h1234 at addr 11) -> port 0 accepted first, port 1 next cycle. ram_write_en high for two consecutive cycles with addr 10 then 11.
- Port 0 reads addr 10, then port 1 reads addr 11, back-to-back -> rsp_valid[0] with 16'hABCD two edges after its acceptance, then rsp_valid[1] with 16'h1234 the following cycle.
- Both ports held valid for 8 cycles with mixed reads/writes -> grants strictly alternate, 4 per port. Each read's response reaches the issuing port only.
- Port 1 alone issues 5 consecutive reads at addrs 0 to 4 -> accepted every cycle, 5 consecutive rsp_valid[1] pulses, data in address order.
- Port 0 writes 16'h5A5A to addr 20, then reads addr 20 on the next cycle -> rsp_rdata = 16'h5A5A.
- Read accepted, then rst asserted one cycle later -> no rsp_valid, ram enables 0, pointer back to port 0.
